// File: rtl/cache_line_mover_if.sv
// -----------------------------------------------------------------------------
// cache_line_mover_if
//
// Bundles every non-clock signal of the cache line mover: the cache-side
// request/done handshake, the victim-line read port, the fill write port and
// the RAM write/read pins.
//
// Modports:
//   master : the mover (drives req_ready, done, fill_*, wb_rd_idx, ram_*)
//   slave  : the cache controller plus RAM (drives req_*, wb_rd_data, ram_dout)
//
// Signal summary:
//   req_valid/req_ready : request handshake, transfer accepted when both high
//                         at a rising clock edge
//   req_wb              : victim is dirty, write it back before the fill
//   req_wb_line         : victim line address
//   req_fill_line       : refill line address
//   wb_rd_idx/wb_rd_data: victim word select and its (combinational) data
//   fill_we/idx/data    : one refill word per cycle into the cache data array
//   done                : one-cycle completion pulse
//   ram_we/waddr/din    : RAM write port
//   ram_raddr/ram_dout  : RAM zero-latency read port
// -----------------------------------------------------------------------------
interface cache_line_mover_if #(
  parameter int ADDR_WIDTH     = 12,
  parameter int DATA_WIDTH     = 32,
  parameter int WORDS_PER_LINE = 4
);
  localparam int OFF_W  = $clog2(WORDS_PER_LINE);
  localparam int LINE_W = ADDR_WIDTH - OFF_W;

  // request handshake
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_wb;
  logic [LINE_W-1:0]     req_wb_line;
  logic [LINE_W-1:0]     req_fill_line;

  // victim line read from the cache
  logic [OFF_W-1:0]      wb_rd_idx;
  logic [DATA_WIDTH-1:0] wb_rd_data;

  // refill write into the cache
  logic                  fill_we;
  logic [OFF_W-1:0]      fill_idx;
  logic [DATA_WIDTH-1:0] fill_data;

  logic                  done;

  // RAM pins
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_waddr;
  logic [DATA_WIDTH-1:0] ram_din;
  logic [ADDR_WIDTH-1:0] ram_raddr;
  logic [DATA_WIDTH-1:0] ram_dout;

  modport master (
    input  req_valid, req_wb, req_wb_line, req_fill_line,
    input  wb_rd_data, ram_dout,
    output req_ready, wb_rd_idx, fill_we, fill_idx, fill_data, done,
    output ram_we, ram_waddr, ram_din, ram_raddr
  );

  modport slave (
    output req_valid, req_wb, req_wb_line, req_fill_line,
    output wb_rd_data, ram_dout,
    input  req_ready, wb_rd_idx, fill_we, fill_idx, fill_data, done,
    input  ram_we, ram_waddr, ram_din, ram_raddr
  );
endinterface

// File: rtl/cache_line_mover.sv
// -----------------------------------------------------------------------------
// cache_line_mover
//
// Cache-side initiator for the word RAM that backs the cache. On a miss it
// optionally writes the dirty victim line back to RAM one word per cycle, then
// reads the refill line one word per cycle and streams it into the cache data
// array. It is the sole master of the RAM pins.
//
// Ports:
//   clk       : clock, everything on the rising edge
//   rst_n     : synchronous active-low reset
//   bus       : cache_line_mover_if.master (request, victim read, fill write,
//               done pulse, RAM write/read pins)
//   dbg_state : current FSM state (0 IDLE, 1 WB, 2 FILL, 3 DONE)
//
// Handshake: a transfer is accepted at a rising edge where req_valid and
// req_ready are both high. req_ready is high only in IDLE; request fields are
// sampled only at that edge, and req_valid seen while busy is ignored (not
// queued). done pulses for exactly one cycle when the transfer completes.
// -----------------------------------------------------------------------------
module cache_line_mover #(
  parameter int ADDR_WIDTH     = 12,
  parameter int DATA_WIDTH     = 32,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  cache_line_mover_if.master       bus,
  output logic [1:0]               dbg_state
);

  localparam int OFF_W  = $clog2(WORDS_PER_LINE);
  localparam int LINE_W = ADDR_WIDTH - OFF_W;
  localparam logic [OFF_W-1:0] LAST_IDX = OFF_W'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [OFF_W-1:0]    cnt_q, cnt_d;
  logic [LINE_W-1:0]   wb_line_q;
  logic [LINE_W-1:0]   fill_line_q;
  logic                accept;

  // decoded controls (from registered state only)
  logic                req_ready_c;
  logic                ram_we_c;
  logic                fill_we_c;
  logic                done_c;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wb_line_q   <= '0;
      fill_line_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        wb_line_q   <= bus.req_wb_line;
        fill_line_q <= bus.req_fill_line;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and control decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    accept      = 1'b0;
    req_ready_c = 1'b0;
    ram_we_c    = 1'b0;
    fill_we_c   = 1'b0;
    done_c      = 1'b0;

    unique case (state_q)
      IDLE: begin
        req_ready_c = 1'b1;
        if (bus.req_valid) begin
          accept  = 1'b1;
          cnt_d   = '0;
          state_d = bus.req_wb ? WB : FILL;
        end
      end

      WB: begin
        ram_we_c = 1'b1;
        // cnt wraps to zero on the last word, which is exactly the start
        // index the fill phase needs
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = FILL;
        end
      end

      FILL: begin
        fill_we_c = 1'b1;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = DONE;
        end
      end

      DONE: begin
        done_c  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs. Addresses and indices are always driven from the line registers
  // and cnt; only the write enables are qualified by state. The two data
  // paths are pure pass-throughs.
  // ---------------------------------------------------------------------------
  assign bus.req_ready = req_ready_c;
  assign bus.done      = done_c;

  assign bus.ram_we    = ram_we_c;
  assign bus.ram_waddr = {wb_line_q, cnt_q};
  assign bus.ram_din   = bus.wb_rd_data;
  assign bus.wb_rd_idx = cnt_q;

  assign bus.ram_raddr = {fill_line_q, cnt_q};
  assign bus.fill_we   = fill_we_c;
  assign bus.fill_idx  = cnt_q;
  assign bus.fill_data = bus.ram_dout;

  assign dbg_state     = state_q;

endmodule

// File: tb/tb_cache_line_mover.sv
module tb_cache_line_mover;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int W  = 4;
  localparam int OW = $clog2(W);
  localparam int LW = AW - OW;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;

  cache_line_mover_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WORDS_PER_LINE(W)) bus ();

  cache_line_mover #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WORDS_PER_LINE(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Environment: word RAM (sync write, async read) and victim line buffer
  // ---------------------------------------------------------------------------
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] vict [0:W-1];
  bit            mem_init_done = 1'b0;

  function automatic logic [DW-1:0] init_val(input int a);
    return DW'(a) + 32'h90;
  endfunction

  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int a = 0; a < (1 << AW); a++) mem[a] <= init_val(a);
      mem_init_done <= 1'b1;
    end else if (bus.ram_we) begin
      mem[bus.ram_waddr] <= bus.ram_din;
    end
  end

  assign bus.ram_dout   = mem[bus.ram_raddr];
  assign bus.wb_rd_data = vict[bus.wb_rd_idx];

  // ---------------------------------------------------------------------------
  // Reference model: RAM image plus expected fill stream
  // ---------------------------------------------------------------------------
  logic [DW-1:0]      ref_mem [int];
  logic [OW+DW-1:0]   exp_q[$];

  function automatic logic [DW-1:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  function automatic int line_addr(input logic [LW-1:0] line, input int i);
    logic [OW-1:0] ii;
    ii = OW'(i);
    return int'({line, ii});
  endfunction

  // ---------------------------------------------------------------------------
  // Scoreboard counters and checker
  // ---------------------------------------------------------------------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic set_victim(input logic [DW-1:0] base, input bit rnd);
    for (int i = 0; i < W; i++) vict[i] = rnd ? DW'($urandom) : base + DW'(i);
  endtask

  // Runs one transfer starting from a negedge in an IDLE cycle; returns at the
  // negedge of the first IDLE cycle after completion.
  task automatic xfer(input bit wb, input logic [LW-1:0] wl, input logic [LW-1:0] fl,
                      input bit hold);
    int  exp_done, fill_base, nfill, nwr;
    bit  seen_done;
    // model: write-back first, then the fill sees the updated image
    if (wb) for (int i = 0; i < W; i++) ref_mem[line_addr(wl, i)] = vict[i];
    exp_q.delete();
    for (int i = 0; i < W; i++) exp_q.push_back({OW'(i), ref_rd(line_addr(fl, i))});
    fill_base = wb ? W : 0;
    exp_done  = fill_base + W + 1;

    check("ready_idle", bus.req_ready, 1);
    bus.req_valid     = 1'b1;
    bus.req_wb        = wb;
    bus.req_wb_line   = wl;
    bus.req_fill_line = fl;
    @(posedge clk);

    seen_done = 0; nfill = 0; nwr = 0;
    for (int k = 1; k <= 2 * W + 4 && !seen_done; k++) begin
      @(negedge clk);
      if (k == 1) check("ready_busy", bus.req_ready, 0);
      if (bus.ram_we) begin
        check("wb_addr", bus.ram_waddr, 64'(line_addr(wl, nwr)));
        check("wb_din", bus.ram_din, vict[nwr % W]);
        check("wb_cycle", 64'(k), 64'(nwr + 1));
        nwr++;
      end
      if (bus.fill_we) begin
        if (exp_q.size() == 0) check("fill_extra", 1, 0);
        else begin
          check("fill_word", {bus.fill_idx, bus.fill_data}, exp_q.pop_front());
          check("fill_cycle", 64'(k), 64'(fill_base + nfill + 1));
        end
        nfill++;
      end
      if (bus.done) begin
        check("done_cycle", 64'(k), 64'(exp_done));
        seen_done = 1;
      end
      if (hold) begin
        bus.req_wb        = 1'($urandom);
        bus.req_wb_line   = LW'($urandom);
        bus.req_fill_line = LW'($urandom);
      end else begin
        bus.req_valid = 1'b0;
      end
    end
    if (!seen_done) check("done_timeout", 0, 1);
    check("fill_count", 64'(nfill), 64'(W));
    check("wr_count", 64'(nwr), 64'(wb ? W : 0));
    bus.req_valid = 1'b0;

    @(negedge clk);
    check("ready_after", bus.req_ready, 1);
    check("done_once", bus.done, 0);
    if (wb) for (int i = 0; i < W; i++)
      check("ram_line", mem[line_addr(wl, i)], ref_rd(line_addr(wl, i)));
  endtask

  // Reset asserted during the second write-back cycle.
  task automatic xfer_abort(input logic [LW-1:0] wl, input logic [LW-1:0] fl);
    int busy;
    for (int i = 0; i < 2; i++) ref_mem[line_addr(wl, i)] = vict[i];
    bus.req_valid     = 1'b1;
    bus.req_wb        = 1'b1;
    bus.req_wb_line   = wl;
    bus.req_fill_line = fl;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("abort_we1", bus.ram_we, 1);
    @(negedge clk);
    check("abort_we2", bus.ram_we, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_ready", bus.req_ready, 1);
    check("abort_we_off", bus.ram_we, 0);
    check("abort_fill_off", bus.fill_we, 0);
    check("abort_done_off", bus.done, 0);
    rst_n = 1'b1;
    busy = 0;
    for (int k = 0; k < 2 * W + 2; k++) begin
      @(negedge clk);
      if (bus.ram_we || bus.fill_we || bus.done) busy++;
    end
    check("abort_quiet", 64'(busy), 0);
    for (int i = 0; i < W; i++)
      check("abort_ram", mem[line_addr(wl, i)], ref_rd(line_addr(wl, i)));
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst_n             = 1'b0;
    bus.req_valid     = 1'b0;
    bus.req_wb        = 1'b0;
    bus.req_wb_line   = '0;
    bus.req_fill_line = '0;
    set_victim('0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("rst_ready", bus.req_ready, 1);
    check("rst_done", bus.done, 0);
    check("rst_ram_we", bus.ram_we, 0);
    check("rst_fill_we", bus.fill_we, 0);
    check("rst_waddr", bus.ram_waddr, 0);
    check("rst_raddr", bus.ram_raddr, 0);
    check("rst_wb_idx", bus.wb_rd_idx, 0);
    check("rst_fill_idx", bus.fill_idx, 0);

    // clean miss: fill words 0xA0..0xA3 from line 0x004
    xfer(1'b0, LW'(0), LW'(12'h004), 1'b0);
    // dirty miss: victim 0xD00.. to line 0x003, then fill line 0x004
    set_victim(32'hD00, 0);
    xfer(1'b1, LW'(12'h003), LW'(12'h004), 1'b0);
    // same line write-back and fill
    set_victim(32'h55, 0);
    xfer(1'b1, LW'(12'h005), LW'(12'h005), 1'b0);
    // req_valid held with changing request fields during the transfer
    set_victim(32'h700, 0);
    xfer(1'b1, LW'(12'h020), LW'(12'h021), 1'b1);
    xfer(1'b0, LW'(12'h022), LW'(12'h020), 1'b1);

    // randomized transfers over a small line range to force overlaps
    for (int n = 0; n < 24; n++) begin
      set_victim('0, 1);
      xfer(1'($urandom), LW'($urandom_range(0, 15)), LW'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)));
    end

    // reset during write-back, then confirm recovery
    set_victim(32'hE00, 0);
    xfer_abort(LW'(12'h030), LW'(12'h031));
    set_victim(32'hF00, 0);
    xfer(1'b1, LW'(12'h031), LW'(12'h030), 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
